// File: rtl/pc_gen.sv
// Fetch-stage PC generator: trap > mret > branch > sequential, new PC visible one cycle after selection.
// Stall holds the PC and parks the latest redirect in a one-entry latch until the stall drops.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 16,
    parameter bit              VECT_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            inst_is_c_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic            trap_irq_i,
    input  logic [4:0]      trap_cause_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Address bits that must be zero for a legal instruction address.
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 32) ? XLEN'(3) : XLEN'(1);
    localparam logic [XLEN-1:0] STEP_C     = (IALIGN == 16) ? XLEN'(2) : XLEN'(4);
    localparam logic [XLEN-1:0] STEP_W     = XLEN'(4);

    logic [0:0]      state;
    logic [XLEN-1:0] pend_tgt;

    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] mret_tgt;
    logic            br_misal;
    logic            redir_vld;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] pc_seq;

    always_comb begin
        trap_base = {mtvec_i[XLEN-1:2], 2'b00};
        if (VECT_EN && (mtvec_i[1:0] == 2'b01) && trap_irq_i)
            trap_tgt = trap_base + {{(XLEN-7){1'b0}}, trap_cause_i, 2'b00};
        else
            trap_tgt = trap_base;

        mret_tgt   = mepc_i & ~ALIGN_MASK;
        br_misal   = |(br_target_i & ALIGN_MASK);
        misalign_o = br_taken_i && br_misal && !trap_i && !mret_i;
        redir_vld  = trap_i || mret_i || (br_taken_i && !br_misal);

        if (trap_i)
            redir_tgt = trap_tgt;
        else if (mret_i)
            redir_tgt = mret_tgt;
        else
            redir_tgt = br_target_i;

        pc_seq = pc_o + (inst_is_c_i ? STEP_C : STEP_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_o       <= RESET_VEC;
            redirect_o <= 1'b0;
            state      <= ST_IDLE;
            pend_tgt   <= '0;
        end else begin
            redirect_o <= 1'b0;
            if (stall_i) begin
                // Latest redirect seen during the stall wins.
                if (redir_vld) begin
                    pend_tgt <= redir_tgt;
                    state    <= ST_PEND;
                end
            end else if (redir_vld) begin
                pc_o       <= redir_tgt;
                redirect_o <= 1'b1;
                state      <= ST_IDLE;
            end else if (state == ST_PEND) begin
                pc_o       <= pend_tgt;
                redirect_o <= 1'b1;
                state      <= ST_IDLE;
            end else if (!misalign_o) begin
                pc_o <= pc_seq;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed checks for pc_gen: sequential stepping, redirects, stall latch, trap vectoring, alignment, reset.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        inst_is_c_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        trap_i;
    logic        trap_irq_i;
    logic [4:0]  trap_cause_i;
    logic [31:0] mtvec_i;
    logic        mret_i;
    logic [31:0] mepc_i;
    logic [31:0] pc_o;
    logic        redirect_o;
    logic        misalign_o;

    int checks   = 0;
    int failures = 0;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(16), .VECT_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .inst_is_c_i  (inst_is_c_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .trap_i       (trap_i),
        .trap_irq_i   (trap_irq_i),
        .trap_cause_i (trap_cause_i),
        .mtvec_i      (mtvec_i),
        .mret_i       (mret_i),
        .mepc_i       (mepc_i),
        .pc_o         (pc_o),
        .redirect_o   (redirect_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; inst_is_c_i = 1'b0;
        br_taken_i = 1'b0; br_target_i = '0;
        trap_i = 1'b0; trap_irq_i = 1'b0; trap_cause_i = '0; mtvec_i = '0;
        mret_i = 1'b0; mepc_i = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_redir", {31'b0, redirect_o}, 32'h0);

        // Sequential steps +4, +2, +4
        inst_is_c_i = 1'b0; tick(); chk("seq4", pc_o, 32'h4);
        inst_is_c_i = 1'b1; tick(); chk("seq2", pc_o, 32'h6);
        inst_is_c_i = 1'b0; tick(); chk("seq4b", pc_o, 32'hA);
        chk("seq_redir", {31'b0, redirect_o}, 32'h0);

        // Unstalled branch
        br_taken_i = 1'b1; br_target_i = 32'h80; tick();
        br_taken_i = 1'b0;
        chk("br_pc", pc_o, 32'h80);
        chk("br_redir", {31'b0, redirect_o}, 32'h1);
        tick();
        chk("br_after_pc", pc_o, 32'h84);
        chk("br_pulse_once", {31'b0, redirect_o}, 32'h0);

        // Branch latched during a 3-cycle stall
        stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h40; tick();
        br_taken_i = 1'b0;
        chk("stall_hold1", pc_o, 32'h84);
        chk("stall_noredir", {31'b0, redirect_o}, 32'h0);
        tick(); tick();
        chk("stall_hold3", pc_o, 32'h84);
        stall_i = 1'b0; tick();
        chk("pend_pc", pc_o, 32'h40);
        chk("pend_redir", {31'b0, redirect_o}, 32'h1);
        tick();
        chk("pend_after", pc_o, 32'h44);
        chk("pend_pulse_once", {31'b0, redirect_o}, 32'h0);

        // Trap vectoring
        trap_i = 1'b1; trap_irq_i = 1'b1; trap_cause_i = 5'd7; mtvec_i = 32'h101; tick();
        chk("trap_vect", pc_o, 32'h11C);
        chk("trap_redir", {31'b0, redirect_o}, 32'h1);
        trap_irq_i = 1'b0; tick();
        chk("trap_direct", pc_o, 32'h100);
        chk("trap_redir_b2b", {31'b0, redirect_o}, 32'h1);

        // Priority trap > mret > branch, then mret alone
        mret_i = 1'b1; mepc_i = 32'h203; br_taken_i = 1'b1; br_target_i = 32'h80;
        trap_cause_i = 5'd3;
        #1 chk("prio_nomisal", {31'b0, misalign_o}, 32'h0);
        tick();
        chk("prio_trap", pc_o, 32'h100);
        trap_i = 1'b0; br_taken_i = 1'b0; tick();
        chk("mret_pc", pc_o, 32'h202);
        mret_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h80; mret_i = 1'b1; tick();
        chk("mret_over_br", pc_o, 32'h202);
        mret_i = 1'b0; br_taken_i = 1'b0;

        // Latest redirect wins while pending, then a live redirect beats the pending one
        stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h300; tick();
        br_target_i = 32'h400; tick();
        stall_i = 1'b0; br_taken_i = 1'b0; tick();
        chk("pend_latest", pc_o, 32'h400);
        stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h500; tick();
        stall_i = 1'b0; br_target_i = 32'h600; tick();
        br_taken_i = 1'b0;
        chk("live_beats_pend", pc_o, 32'h600);
        tick();
        chk("no_stale_pend", pc_o, 32'h604);

        // Wrap, misaligned branch, reset during PEND
        br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFE; tick();
        br_taken_i = 1'b0; chk("wrap_setup", pc_o, 32'hFFFF_FFFE);
        inst_is_c_i = 1'b1; tick();
        inst_is_c_i = 1'b0; chk("wrap", pc_o, 32'h0);
        br_taken_i = 1'b1; br_target_i = 32'h41;
        #1 chk("misal_flag", {31'b0, misalign_o}, 32'h1);
        trap_i = 1'b1;
        #1 chk("misal_masked", {31'b0, misalign_o}, 32'h0);
        trap_i = 1'b0;
        tick();
        br_taken_i = 1'b0;
        chk("misal_hold", pc_o, 32'h0);
        chk("misal_noredir", {31'b0, redirect_o}, 32'h0);
        stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h80; tick();
        br_taken_i = 1'b0; reset = 1'b1; tick();
        reset = 1'b0; stall_i = 1'b0;
        chk("rst_pend_pc", pc_o, 32'h0);
        tick();
        chk("rst_pend_discard", pc_o, 32'h4);
        chk("rst_pend_noredir", {31'b0, redirect_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
